// File: rtl/nios_fprint_scratchpad_dma_master_pkg.sv
// Shared constants, FSM state encoding and address helper for the scratchpad DMA master.
package nios_fprint_sp_pkg;

  localparam int SP_AW = 12;
  localparam int DW    = 32;
  localparam int BEW   = DW / 8;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Scratchpad addresses wrap modulo the RAM depth.
  function automatic logic [SP_AW-1:0] addr_inc(input logic [SP_AW-1:0] a);
    return a + {{(SP_AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/nios_fprint_scratchpad_dma_master_if.sv
// Scratchpad Avalon-MM bus plus the Avalon-ST source/sink pair seen by the DMA master.
interface nios_fprint_scratchpad_dma_master_if;
  import nios_fprint_sp_pkg::*;

  logic [SP_AW-1:0] sp_address;
  logic [BEW-1:0]   sp_byteenable;
  logic             sp_chipselect;
  logic             sp_write;
  logic [DW-1:0]    sp_writedata;
  logic             sp_clken;
  logic [DW-1:0]    sp_readdata;

  logic [DW-1:0]    src_data;
  logic             src_valid;
  logic             src_last;
  logic             src_ready;

  logic [DW-1:0]    snk_data;
  logic             snk_valid;
  logic             snk_ready;

  modport master (
    output sp_address, sp_byteenable, sp_chipselect, sp_write, sp_writedata, sp_clken,
    input  sp_readdata,
    output src_data, src_valid, src_last,
    input  src_ready,
    input  snk_data, snk_valid,
    output snk_ready
  );

  modport slave (
    input  sp_address, sp_byteenable, sp_chipselect, sp_write, sp_writedata, sp_clken,
    output sp_readdata,
    input  src_data, src_valid, src_last,
    output src_ready,
    output snk_data, snk_valid,
    input  snk_ready
  );

endinterface

// File: rtl/nios_fprint_scratchpad_dma_master_rd_fifo.sv
// Small synchronous FIFO buffering scratchpad read returns; flush wins over a same-cycle push.
module nios_fprint_sp_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign w_pop  = i_pop && (r_count != {CW{1'b0}});
  assign w_push = i_push && ((r_count != CNT_FULL) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == {CW{1'b0}});

endmodule

// File: rtl/nios_fprint_scratchpad_dma_master.sv
// Avalon-MM master moving word blocks between the scratchpad RAM and an Avalon-ST source/sink.
module nios_fprint_scratchpad_dma_master
  import nios_fprint_sp_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_dir,
  input  logic [SP_AW-1:0]   i_base_addr,
  input  logic [SP_AW:0]     i_length,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted,
  nios_fprint_scratchpad_dma_master_if.master dma
);

  localparam int             CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]    DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [SP_AW:0] LEN_ONE = (SP_AW + 1)'(1);

  state_e           r_state;
  logic [SP_AW-1:0] r_addr;
  logic [SP_AW:0]   r_len;
  logic [SP_AW:0]   r_issue_cnt;
  logic [SP_AW:0]   r_pop_cnt;
  logic             r_inflight;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_in_rd;
  logic             w_src_valid;
  logic             w_pop;
  logic [CW:0]      w_used;
  logic             w_rd_issue;
  logic             w_wr_beat;
  logic             w_last_beat;
  logic             w_drain_empty;
  logic             w_flush;
  logic [DW-1:0]    w_fifo_data;
  logic [CW-1:0]    w_fifo_count;
  logic             w_fifo_empty;

  // Issue credit counts the pop happening this cycle so a ready sink sustains one word per clock.
  always_comb begin
    w_in_rd       = (r_state == ST_RD) || (r_state == ST_RD_DRAIN);
    w_src_valid   = w_in_rd && !i_abort && !w_fifo_empty;
    w_pop         = w_src_valid && dma.src_ready;
    w_used        = {1'b0, w_fifo_count} + (CW + 1)'(r_inflight);
    w_rd_issue    = (r_state == ST_RD) && !i_abort && (w_used < (DEPTH_W + (CW + 1)'(w_pop)));
    w_wr_beat     = (r_state == ST_WR) && dma.snk_valid;
    w_last_beat   = ((r_issue_cnt + LEN_ONE) == r_len);
    w_drain_empty = !r_inflight && (w_fifo_count == CW'(w_pop));
    w_flush       = w_in_rd && i_abort;
  end

  nios_fprint_sp_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW),
    .CW    (CW)
  ) u_rd_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (r_inflight),
    .i_data  (dma.sp_readdata),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // Transfer FSM with address/beat bookkeeping and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= {SP_AW{1'b0}};
      r_len       <= {(SP_AW + 1){1'b0}};
      r_issue_cnt <= {(SP_AW + 1){1'b0}};
      r_pop_cnt   <= {(SP_AW + 1){1'b0}};
      r_inflight  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_inflight <= w_rd_issue;
      if (w_pop) r_pop_cnt <= r_pop_cnt + LEN_ONE;
      case (r_state)
        ST_IDLE: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_len       <= i_length;
            r_issue_cnt <= {(SP_AW + 1){1'b0}};
            r_pop_cnt   <= {(SP_AW + 1){1'b0}};
            if (i_length == {(SP_AW + 1){1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (i_dir == DIR_WRITE) begin
              r_state <= ST_WR;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_RD;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (i_abort) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_rd_issue) begin
            r_addr      <= addr_inc(r_addr);
            r_issue_cnt <= r_issue_cnt + LEN_ONE;
            if (w_last_beat) r_state <= ST_RD_DRAIN;
          end
        end
        ST_RD_DRAIN: begin
          if (i_abort) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_drain_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_WR: begin
          // A final beat coinciding with abort still completes normally.
          if (w_wr_beat) begin
            r_addr      <= addr_inc(r_addr);
            r_issue_cnt <= r_issue_cnt + LEN_ONE;
          end
          if (w_wr_beat && w_last_beat) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (i_abort) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_aborted = r_aborted;

  assign dma.sp_address    = r_addr;
  assign dma.sp_byteenable = {BEW{reset_n}};
  assign dma.sp_clken      = reset_n;
  assign dma.sp_chipselect = w_rd_issue || w_wr_beat;
  assign dma.sp_write      = w_wr_beat;
  assign dma.sp_writedata  = w_wr_beat ? dma.snk_data : {DW{1'b0}};

  assign dma.src_valid = w_src_valid;
  assign dma.src_data  = w_src_valid ? w_fifo_data : {DW{1'b0}};
  assign dma.src_last  = w_src_valid && (r_pop_cnt == (r_len - LEN_ONE));
  assign dma.snk_ready = (r_state == ST_WR);

endmodule

// File: tb/tb_nios_fprint_scratchpad_dma_master.sv
// Directed bench: table of read/write transfers against a RAM model, plus abort/len0/reset sequences.
module tb_nios_fprint_scratchpad_dma_master;
  import nios_fprint_sp_pkg::*;

  typedef struct {
    logic        dir;
    logic [11:0] base;
    logic [12:0] len;
    logic        toggle;
    int          exp_strobes;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic        i_dir;
  logic [11:0] i_base_addr;
  logic [12:0] i_length;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic        ram_fill;
  logic [31:0] ram [4096];
  logic [31:0] exp_mem [4096];
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  nios_fprint_scratchpad_dma_master_if bus ();

  nios_fprint_scratchpad_dma_master #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .i_dir       (i_dir),
    .i_base_addr (i_base_addr),
    .i_length    (i_length),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .dma         (bus)
  );

  function automatic logic [31:0] init_pat(input logic [11:0] a);
    return {20'hA0A0A, a};
  endfunction

  function automatic logic [31:0] wpat(input logic [11:0] b, input int i);
    logic [11:0] lo;
    lo = 12'(i);
    return {8'hD0, b, lo};
  endfunction

  // Scratchpad model: 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_pat(12'(i));
    end else begin
      if (bus.sp_chipselect && bus.sp_write) ram[bus.sp_address] <= bus.sp_writedata;
      if (bus.sp_chipselect && !bus.sp_write) bus.sp_readdata <= ram[bus.sp_address];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic start_xfer(input logic dir, input logic [11:0] base, input logic [12:0] len);
    i_start     = 1'b1;
    i_dir       = dir;
    i_base_addr = base;
    i_length    = len;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          words, strobes, issued, first_cyc, last_cyc, done_cyc;
    logic        hold_pend;
    logic [31:0] hold_data;
    logic [11:0] a;
    words = 0; strobes = 0; issued = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    hold_pend = 1'b0; hold_data = 32'h0;
    start_xfer(v.dir, v.base, v.len);
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      bus.src_ready = (v.dir == DIR_READ) ? (v.toggle ? (cyc % 2 == 1) : 1'b1) : 1'b0;
      bus.snk_valid = (v.dir == DIR_WRITE) ? (v.toggle ? (cyc % 2 == 1) : 1'b1) : 1'b0;
      bus.snk_data  = wpat(v.base, words);
      @(negedge clk);
      a = v.base + 12'(words);
      if (cyc == 1) chk("busy_after_start", 32'(o_busy), 32'(1));
      if (bus.sp_chipselect) strobes++;
      if (bus.sp_chipselect && !bus.sp_write) issued++;
      if (hold_pend && bus.src_valid) chk("src_hold_stable", bus.src_data, hold_data);
      hold_pend = bus.src_valid && !bus.src_ready;
      hold_data = bus.src_data;
      if (bus.src_valid && bus.src_ready) begin
        chk("rd_data", bus.src_data, exp_mem[a]);
        chk("rd_last", 32'(bus.src_last), 32'(words == int'(v.len) - 1));
        words++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (bus.snk_valid && bus.snk_ready) begin
        chk("wr_strobe", 32'({bus.sp_chipselect, bus.sp_write}), 32'(3));
        chk("wr_addr", 32'(bus.sp_address), 32'(a));
        chk("wr_data", bus.sp_writedata, wpat(v.base, words));
        exp_mem[a] = wpat(v.base, words);
        words++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (issued - words > 2) chk("inflight_le2", 32'(issued - words), 32'(2));
      if (o_done) begin
        done_cyc = cyc;
        chk("done_not_aborted", 32'(o_aborted), 32'(0));
        chk("busy_low_at_done", 32'(o_busy), 32'(0));
      end
      @(posedge clk); #1;
    end
    bus.src_ready = 1'b0;
    bus.snk_valid = 1'b0;
    chk("word_count", 32'(words), 32'(v.len));
    chk("strobe_count", 32'(strobes), 32'(v.exp_strobes));
    chk("done_latency", 32'(done_cyc), 32'(last_cyc + 1));
    if (!v.toggle) chk("consecutive", 32'(last_cyc - first_cyc), 32'(int'(v.len) - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   done_cyc, abort_cyc, post_valid, strobes, words;
    logic busy_seen, sent;
    vec_t v;

    vecs[0] = '{DIR_READ,  12'h010, 13'd4, 1'b0, 4};
    vecs[1] = '{DIR_READ,  12'h020, 13'd8, 1'b1, 8};
    vecs[2] = '{DIR_WRITE, 12'hFFE, 13'd4, 1'b0, 4};
    vecs[3] = '{DIR_READ,  12'hFFE, 13'd4, 1'b0, 4};
    vecs[4] = '{DIR_WRITE, 12'h100, 13'd3, 1'b1, 3};
    vecs[5] = '{DIR_READ,  12'h100, 13'd3, 1'b1, 3};

    reset_n = 1'b0; ram_fill = 1'b1;
    i_start = 1'b0; i_dir = 1'b0; i_base_addr = 12'h0; i_length = 13'h0; i_abort = 1'b0;
    bus.src_ready = 1'b0; bus.snk_valid = 1'b0; bus.snk_data = 32'h0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_pat(12'(i));
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl_outs", 32'({o_busy, o_done, o_aborted, bus.sp_address, bus.sp_byteenable,
        bus.sp_chipselect, bus.sp_write, bus.sp_clken, bus.src_valid, bus.src_last, bus.snk_ready}), 32'(0));
    chk("reset_wdata", bus.sp_writedata, 32'h0);
    chk("reset_src_data", bus.src_data, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; ram_fill = 1'b0;
    @(negedge clk);
    chk("be_clken_after_reset", 32'({bus.sp_byteenable, bus.sp_clken}), 32'({4'hF, 1'b1}));
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    chk("ram_FFE", ram[12'hFFE], wpat(12'hFFE, 0));
    chk("ram_FFF", ram[12'hFFF], wpat(12'hFFE, 1));
    chk("ram_000", ram[12'h000], wpat(12'hFFE, 2));
    chk("ram_001", ram[12'h001], wpat(12'hFFE, 3));

    // length 0: immediate done, no busy, no strobes
    start_xfer(DIR_READ, 12'h005, 13'd0);
    done_cyc = -1; busy_seen = 1'b0; strobes = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (o_done && done_cyc < 0) begin
        done_cyc = cyc;
        chk("len0_aborted", 32'(o_aborted), 32'(0));
      end
      busy_seen = busy_seen | o_busy;
      if (bus.sp_chipselect) strobes++;
      @(posedge clk); #1;
    end
    chk("len0_done_cyc", 32'(done_cyc), 32'(1));
    chk("len0_busy", 32'(busy_seen), 32'(0));
    chk("len0_strobes", 32'(strobes), 32'(0));

    // abort while idle is ignored
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", 32'({o_done, o_busy, o_aborted}), 32'(0));
    @(posedge clk); #1;

    // read 100 words, abort after the 10th word
    start_xfer(DIR_READ, 12'h200, 13'd100);
    words = 0; post_valid = 0; done_cyc = -1; abort_cyc = -1; sent = 1'b0;
    bus.src_ready = 1'b1;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      i_abort = (words == 10) && !sent;
      if (i_abort) begin
        sent = 1'b1;
        abort_cyc = cyc;
      end
      @(negedge clk);
      if (bus.src_valid) begin
        if (sent) post_valid++;
        else begin
          chk("abort_rd_data", bus.src_data, exp_mem[12'h200 + 12'(words)]);
          words++;
        end
      end
      if (o_done) begin
        done_cyc = cyc;
        chk("abort_flag", 32'(o_aborted), 32'(1));
        chk("abort_fifo_empty", 32'(dut.w_fifo_count), 32'(0));
      end
      @(posedge clk); #1;
      i_abort = 1'b0;
    end
    bus.src_ready = 1'b0;
    chk("abort_words", 32'(words), 32'(10));
    chk("abort_no_valid_after", 32'(post_valid), 32'(0));
    chk("abort_done_cyc", 32'(done_cyc), 32'(abort_cyc + 1));
    v = '{DIR_READ, 12'h204, 13'd3, 1'b0, 3};
    run_vec(v);

    // reset mid-write after three beats
    start_xfer(DIR_WRITE, 12'h300, 13'd8);
    for (int k = 0; k < 3; k++) begin
      bus.snk_valid = 1'b1;
      bus.snk_data  = wpat(12'h300, k);
      exp_mem[12'h300 + 12'(k)] = wpat(12'h300, k);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl_outs", 32'({o_busy, o_done, o_aborted, bus.sp_address, bus.sp_byteenable,
        bus.sp_chipselect, bus.sp_write, bus.sp_clken, bus.src_valid, bus.src_last, bus.snk_ready}), 32'(0));
    chk("midrst_wdata", bus.sp_writedata, 32'h0);
    bus.snk_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ram_300", ram[12'h300], wpat(12'h300, 0));
    chk("midrst_ram_302", ram[12'h302], wpat(12'h300, 2));
    chk("midrst_ram_303", ram[12'h303], init_pat(12'h303));
    v = '{DIR_WRITE, 12'h310, 13'd2, 1'b0, 2};
    run_vec(v);
    v = '{DIR_READ, 12'h300, 13'd4, 1'b0, 4};
    run_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
